// File: rtl/bitsim_enc_pkg.sv
// bitsim_enc_pkg: shared FSM state type and grouping constants for the weight column encoder.
package bitsim_enc_pkg;
    typedef enum logic {IDLE, RUN} state_t;
    localparam int GROUP_SIZE    = 8;
    localparam int MUX_PER_GROUP = 4;
    localparam int MUX_WINDOW    = 5;
    localparam int SEL_W         = $clog2(MUX_WINDOW);
endpackage

// File: rtl/bitsim_group_col_encoder.sv
// bitsim_group_col_encoder: maps one 8-lane column slice onto four 5:1 mux selects.
// Ports: bits (column bit of each lane) in; sel/val per mux output, is_skip_zero (1 = ones are targets) out.
module bitsim_group_col_encoder
    import bitsim_enc_pkg::*;
(
    input  logic [GROUP_SIZE-1:0]               bits,
    output logic [MUX_PER_GROUP-1:0][SEL_W-1:0] sel,
    output logic [MUX_PER_GROUP-1:0]            val,
    output logic                                is_skip_zero
);
    logic [GROUP_SIZE-1:0] tgt;
    logic [GROUP_SIZE-1:0] taken;
    logic [3:0]            ones;
    logic                  found;
    always_comb begin
        ones = '0;
        for (int k = 0; k < GROUP_SIZE; k++) ones = ones + 4'(bits[k]);
        // Target the minority polarity so at most four lanes need a mux; ties favour the ones.
        is_skip_zero = ones <= 4'd4;
        tgt = is_skip_zero ? bits : ~bits;
        taken = '0;
        sel = '0;
        val = '0;
        found = 1'b0;
        // Output j sees lanes j..j+4; taking the lowest free lane first leaves the high lanes to the later outputs.
        for (int j = 0; j < MUX_PER_GROUP; j++) begin
            found = 1'b0;
            for (int d = 0; d < MUX_WINDOW; d++)
                if (!found && tgt[j+d] && !taken[j+d]) begin
                    found = 1'b1;
                    val[j] = 1'b1;
                    sel[j] = SEL_W'(d);
                    taken[j+d] = 1'b1;
                end
        end
    end
endmodule

// File: rtl/bitsim_weight_col_encoder.sv
// bitsim_weight_col_encoder: latches a weight vector and emits one mux-control beat per bit column, MSB first.
// Ports: clk, reset (async active-low); w_valid/w_ready/weight vector input handshake;
//   ctrl_valid/ctrl_ready/ctrl_last beat handshake with act_sel, act_val, is_skip_zero, column_idx, is_msb;
//   mul_const, is_shift_mul, en_mul are tied off.
// Option: BITSIM_ENC_ZERO_COL_SKIP_EN skips all-zero columns above column 0.
module bitsim_weight_col_encoder
    import bitsim_enc_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int VEC_LENGTH    = 16,
    parameter int MUX_SEL_WIDTH = $clog2(VEC_LENGTH)
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          w_valid,
    output logic                                          w_ready,
    input  logic signed [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  weight,
    output logic                                          ctrl_valid,
    input  logic                                          ctrl_ready,
    output logic                                          ctrl_last,
    output logic [VEC_LENGTH/2-1:0][MUX_SEL_WIDTH-2:0]    act_sel,
    output logic [VEC_LENGTH/2-1:0]                       act_val,
    output logic [VEC_LENGTH/8-1:0]                       is_skip_zero,
    output logic [2:0]                                    column_idx,
    output logic                                          is_msb,
    output logic [2:0]                                    mul_const,
    output logic                                          is_shift_mul,
    output logic                                          en_mul
);
    localparam int NG = VEC_LENGTH / GROUP_SIZE;
    state_t                              state, state_d;
    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] w_q;
    logic [2:0]                          cnt, cnt_d, load_col, next_col;
    logic [VEC_LENGTH-1:0]               col_bits;
    logic                                accept, beat;
`ifdef BITSIM_ENC_ZERO_COL_SKIP_EN
    // Highest column in 1..below-1 holding any set bit, else 0 so column 0 is always emitted.
    function automatic logic [2:0] top_col(input logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] w, input int below);
        logic [DATA_WIDTH-1:0] nz;
        nz = '0;
        top_col = '0;
        for (int l = 0; l < VEC_LENGTH; l++) nz = nz | w[l];
        for (int c = 1; c < DATA_WIDTH; c++) if (c < below && nz[c]) top_col = 3'(c);
    endfunction
    assign load_col = top_col(weight, DATA_WIDTH);
    assign next_col = top_col(w_q, int'(cnt));
`else
    assign load_col = 3'(DATA_WIDTH - 1);
    assign next_col = cnt - 3'd1;
`endif
    always_comb begin
        state_d = state;
        cnt_d = cnt;
        accept = (state == IDLE) && w_valid;
        beat = (state == RUN) && ctrl_ready;
        if (accept) begin
            state_d = RUN;
            cnt_d = load_col;
        end else if (beat) begin
            state_d = (cnt == 3'd0) ? IDLE : RUN;
            cnt_d = (cnt == 3'd0) ? 3'd0 : next_col;
        end
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= IDLE;
            cnt <= '0;
            w_q <= '0;
        end else begin
            state <= state_d;
            cnt <= cnt_d;
            if (accept) w_q <= weight;
        end
    always_comb begin
        col_bits = '0;
        for (int l = 0; l < VEC_LENGTH; l++) col_bits[l] = w_q[l][cnt];
    end
    for (genvar g = 0; g < NG; g++) begin : g_grp
        logic [MUX_PER_GROUP-1:0][SEL_W-1:0] sel;
        bitsim_group_col_encoder u_enc (
            .bits         (col_bits[g*GROUP_SIZE +: GROUP_SIZE]),
            .sel          (sel),
            .val          (act_val[g*MUX_PER_GROUP +: MUX_PER_GROUP]),
            .is_skip_zero (is_skip_zero[g])
        );
        for (genvar j = 0; j < MUX_PER_GROUP; j++) begin : g_sel
            assign act_sel[g*MUX_PER_GROUP+j] = (MUX_SEL_WIDTH-1)'(sel[j]);
        end
    end
    assign w_ready      = state == IDLE;
    assign ctrl_valid   = state == RUN;
    assign ctrl_last    = ctrl_valid && (cnt == 3'd0);
    assign column_idx   = cnt;
    assign is_msb       = cnt == 3'(DATA_WIDTH - 1);
    assign mul_const    = '0;
    assign is_shift_mul = 1'b0;
    assign en_mul       = 1'b0;
endmodule

// File: tb/tb_bitsim_weight_col_encoder.sv
// tb_bitsim_weight_col_encoder: directed table vectors plus stall, reset and skip sequences for the column encoder.
module tb_bitsim_weight_col_encoder;
`ifdef BITSIM_ENC_ZERO_COL_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    typedef struct {
        logic [15:0]      pat;
        int               col;
        logic [1:0]       skz;
        logic [7:0]       val;
        logic [7:0][2:0]  sel;
    } vec_t;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    w_valid, w_ready, ctrl_valid, ctrl_ready, ctrl_last;
    logic signed [15:0][7:0] weight;
    logic [7:0][2:0]         act_sel;
    logic [7:0]              act_val;
    logic [1:0]              is_skip_zero;
    logic [2:0]              column_idx, mul_const;
    logic                    is_msb, is_shift_mul, en_mul;
    int                      total = 0;
    int                      passed = 0;
    vec_t                    vecs [6];

    bitsim_weight_col_encoder dut (
        .clk          (clk),
        .reset        (reset),
        .w_valid      (w_valid),
        .w_ready      (w_ready),
        .weight       (weight),
        .ctrl_valid   (ctrl_valid),
        .ctrl_ready   (ctrl_ready),
        .ctrl_last    (ctrl_last),
        .act_sel      (act_sel),
        .act_val      (act_val),
        .is_skip_zero (is_skip_zero),
        .column_idx   (column_idx),
        .is_msb       (is_msb),
        .mul_const    (mul_const),
        .is_shift_mul (is_shift_mul),
        .en_mul       (en_mul)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0][7:0] mk(input logic [15:0] pat, input logic [7:0] m);
        for (int l = 0; l < 16; l++) mk[l] = pat[l] ? m : 8'h00;
    endfunction

    task automatic load(input logic [15:0][7:0] w);
        int n;
        n = 0;
        while (!w_ready && n < 50) begin
            tick();
            n++;
        end
        weight = w;
        w_valid = 1'b1;
        tick();
        w_valid = 1'b0;
        weight = {8{16'hA5C3}};
    endtask

    task automatic goto_col(input int c);
        int n;
        n = 0;
        while (ctrl_valid && column_idx != 3'(c) && n < 20) begin
            ctrl_ready = 1'b1;
            tick();
            n++;
        end
        ctrl_ready = 1'b0;
        chk("reach_col", {ctrl_valid, column_idx}, {1'b1, 3'(c)});
    endtask

    task automatic drain(output int beats);
        int n;
        beats = 0;
        n = 0;
        ctrl_ready = 1'b1;
        while (ctrl_valid && n < 20) begin
            beats++;
            tick();
            n++;
        end
        ctrl_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int beats;
        int ec;
        vecs[0] = '{16'h00E0, 3, 2'b11, 8'h0E, {3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd4, 3'd4, 3'd0}};
        vecs[1] = '{16'h0F00, 2, 2'b11, 8'hF0, 24'd0};
        vecs[2] = '{16'h1F00, 6, 2'b01, 8'hE0, {3'd4, 3'd4, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}};
        vecs[3] = '{16'h00FF, 1, 2'b10, 8'h00, 24'd0};
        vecs[4] = '{16'h1281, 0, 2'b11, 8'h39, {3'd0, 3'd0, 3'd3, 3'd1, 3'd4, 3'd0, 3'd0, 3'd0}};
        vecs[5] = '{16'hF0F8, 5, 2'b10, 8'hF7, {3'd4, 3'd4, 3'd4, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0}};
        reset = 1'b0;
        w_valid = 1'b0;
        ctrl_ready = 1'b0;
        weight = '0;
        #3;
        chk("rst_valid", ctrl_valid, 0);
        chk("rst_last", ctrl_last, 0);
        chk("rst_act_val", act_val, 0);
        chk("rst_w_ready", w_ready, 1);
        chk("rst_mul", {en_mul, is_shift_mul, mul_const}, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        tick();

        weight = mk(16'hFFFF, 8'h80);
        w_valid = 1'b1;
        chk("pre_accept_valid", ctrl_valid, 0);
        chk("pre_accept_ready", w_ready, 1);
        tick();
        w_valid = 1'b0;
        weight = {8{16'h5A3C}};
        chk("post_accept_valid", ctrl_valid, 1);
        chk("post_accept_ready", w_ready, 0);
        ctrl_ready = 1'b1;
        for (int b = 0; b < (SKIP ? 2 : 8); b++) begin
            ec = SKIP ? (b == 0 ? 7 : 0) : 7 - b;
            chk($sformatf("h80_b%0d_col", b), column_idx, ec);
            chk($sformatf("h80_b%0d_msb", b), is_msb, ec == 7);
            chk($sformatf("h80_b%0d_skz", b), is_skip_zero, ec == 7 ? 2'b00 : 2'b11);
            chk($sformatf("h80_b%0d_val", b), act_val, 0);
            chk($sformatf("h80_b%0d_last", b), ctrl_last, ec == 0);
            tick();
        end
        ctrl_ready = 1'b0;
        chk("h80_idle", {ctrl_valid, w_ready}, 2'b01);

        for (int i = 0; i < 6; i++) begin
            load(mk(vecs[i].pat, 8'(1 << vecs[i].col)));
            goto_col(vecs[i].col);
            chk($sformatf("v%0d_skz", i), is_skip_zero, vecs[i].skz);
            chk($sformatf("v%0d_val", i), act_val, vecs[i].val);
            chk($sformatf("v%0d_sel", i), act_sel, vecs[i].sel);
            chk($sformatf("v%0d_msb", i), is_msb, vecs[i].col == 7);
            chk($sformatf("v%0d_last", i), ctrl_last, vecs[i].col == 0);
            chk($sformatf("v%0d_mul", i), {en_mul, is_shift_mul, mul_const}, 0);
            drain(beats);
            chk($sformatf("v%0d_idle", i), {ctrl_valid, w_ready}, 2'b01);
        end

        load(mk(16'hF0F8, 8'hFF));
        goto_col(5);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("stall%0d_col", k), {ctrl_valid, ctrl_last, column_idx}, {2'b10, 3'd5});
            chk($sformatf("stall%0d_val", k), act_val, 8'hF7);
            chk($sformatf("stall%0d_sel", k), act_sel, vecs[5].sel);
            chk($sformatf("stall%0d_skz", k), is_skip_zero, 2'b10);
            tick();
        end
        ctrl_ready = 1'b1;
        tick();
        ctrl_ready = 1'b0;
        chk("after_stall_col", column_idx, 4);

        #2 reset = 1'b0;
        #1;
        chk("midrst_valid", ctrl_valid, 0);
        chk("midrst_last", ctrl_last, 0);
        chk("midrst_act_val", act_val, 0);
        chk("midrst_w_ready", w_ready, 1);
        @(posedge clk);
        #1 reset = 1'b1;
        tick();
        chk("postrst_state", {ctrl_valid, w_ready}, 2'b01);
        load(mk(16'hF0F8, 8'hFF));
        chk("postrst_col", column_idx, 7);
        chk("postrst_msb", is_msb, 1);
        drain(beats);
        chk("postrst_beats", beats, 8);

        load(mk(16'hFFFF, 8'h01));
        chk("h01_first_col", column_idx, SKIP ? 0 : 7);
        chk("h01_first_last", ctrl_last, SKIP);
        drain(beats);
        chk("h01_beats", beats, SKIP ? 1 : 8);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
